cdm_err_sweep_ctrl: RTL and testbench
=====================================

Name: cdm_err_sweep_ctrl

Overview:
Sequencing controller that drives one carry-disregard approximate multiplier through every operand pair (A outer, B inner, 0..2^W-1 each). It compares each approximate product with the exact product and accumulates error metrics in hardware, replacing file-dump post-processing. The multiplier under test is instantiated outside the block: this block drives its operands and samples its combinational product, so any CDM variant plugs in unchanged.

Parameters:
W, 8, operand width; sweep covers 2^(2W) pairs; product width 2W.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a sweep when the block is idle.
abort  in  1  synchronous; cancels a sweep in progress.
mult_a  out  W  operand A driven to the multiplier (registered).
mult_b  out  W  operand B driven to the multiplier (registered).
mult_r  in  2W  approximate product; combinational function of mult_a/mult_b.
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse; results final.
err_count  out  2W+1  number of pairs with mult_r != exact product.
max_ed  out  2W  maximum |exact - mult_r| over the sweep.
sum_ed  out  4W  sum of |exact - mult_r| over the sweep.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE. mult_a, mult_b, busy, done, err_count, max_ed and sum_ed are all 0. Stage-valid is cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0: clear all accumulators, set mult_a=0 and mult_b=0, go to RUN.
  - Otherwise stay in IDLE. Results hold their last values.
- RUN, one pair per cycle:
  - Compute ed = |mult_a*mult_b - mult_r| (2W bits, exact product zero-extended).
  - Register ed plus an err flag (ed != 0) into the ED stage with valid=1.
  - Increment mult_b. When mult_b is at max, wrap it to 0 and increment mult_a.
  - At mult_a=max and mult_b=max, hold the operands and go to DRAIN.
- DRAIN: lasts 1 cycle; the stage holds the last pair. Then go to DONE.
- Accumulate every cycle the stage is valid:
  - err_count += err.
  - sum_ed += ed.
  - max_ed = max(max_ed, ed).
  - No saturation is needed; the widths cover the worst case.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Latency: start sampled at edge t.
  - busy is high for cycles t+1 .. t+2^(2W)+1.
  - done is high in cycle t+2^(2W)+2.
- start while busy: ignored.
- abort in RUN or DRAIN: go to IDLE next cycle. busy drops, done is not pulsed, stage-valid is cleared, and partial results hold.
- start and abort together in IDLE: abort wins; the block stays in IDLE.
- rst mid-sweep: immediate return to the reset state; no done.
- Operands change only on clock edges, so mult_r is stable for a full cycle before it is sampled.

Decomposition:
- Package cdm_sweep_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - width constants derived from W: PW=2W, CW=2W+1, SW=4W;
  - NPAIRS=2^(2W).
- One sub-module, cdm_ed_stage: registered absolute-difference stage (exact vs approximate product, outputs ed, err and valid).
- Accumulators and FSM stay in the top.

Test Plan:
- W=2, stub mult_r=exact, start at edge t -> done exactly in cycle t+18; err_count=0, max_ed=0, sum_ed=0; busy high cycles t+1..t+17.
- W=2, stub mult_r=exact with LSB forced 0 -> err_count=4, max_ed=1, sum_ed=4.
- W=2, stub mult_r=0 -> err_count=9, max_ed=9, sum_ed=36. Also check mult_a/mult_b order (0,0),(0,1)..(3,3).
- W=2, abort 5 cycles after start -> busy low next cycle, no done pulse, partial results held. A following start clears the results and a full sweep gives correct totals.
- Start pulse during busy and start+abort together in IDLE -> no restart / no sweep. Reset asserted mid-RUN -> all outputs 0 asynchronously.
- W=8 with the team's 8-bit CDM instance -> done at t+65538. err_count, max_ed and sum_ed equal the bench-computed values from an exhaustive golden model.

Source files
------------

// File: rtl/cdm_err_sweep_ctrl_pkg.sv
// Shared types and width helpers for the carry-disregard multiplier error sweep.
// Widths are functions of the operand width so every instance derives its own.
package cdm_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Product, error-count and error-sum widths for operand width w.
  function automatic int cdm_pw(input int w);
    return 2 * w;
  endfunction

  function automatic int cdm_cw(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int cdm_sw(input int w);
    return 4 * w;
  endfunction

  function automatic int cdm_npairs(input int w);
    return 1 << (2 * w);
  endfunction

endpackage

// File: rtl/cdm_err_sweep_ctrl_ed_stage.sv
// Registered error-distance stage: |exact - approximate| for the current operand
// pair, with a nonzero flag and a valid bit that follows i_load.
module cdm_ed_stage
  import cdm_sweep_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic [2*W-1:0]   i_r,
  output logic [2*W-1:0]   o_ed,
  output logic             o_err,
  output logic             o_valid
);

  localparam int PW = cdm_pw(W);

  logic [PW-1:0] w_exact;
  logic [PW-1:0] w_ed;
  logic [PW-1:0] r_ed;
  logic          r_err;
  logic          r_valid;

  assign w_exact = PW'(i_a) * PW'(i_b);
  assign w_ed    = (w_exact >= i_r) ? (w_exact - i_r) : (i_r - w_exact);

  // Valid drops whenever nothing is loaded, so an abort or drain empties the stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ed    <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_load;
      if (i_load) begin
        r_ed  <= w_ed;
        r_err <= |w_ed;
      end
    end
  end

  assign o_ed    = r_ed;
  assign o_err   = r_err;
  assign o_valid = r_valid;

endmodule

// File: rtl/cdm_err_sweep_ctrl.sv
// Exhaustive operand sweep for an external approximate multiplier, accumulating
// error count, maximum and sum of error distance against the exact product.
module cdm_err_sweep_ctrl
  import cdm_sweep_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [W-1:0]     o_mult_a,
  output logic [W-1:0]     o_mult_b,
  input  logic [2*W-1:0]   i_mult_r,
  output logic             o_busy,
  output logic             o_done,
  output logic [2*W:0]     o_err_count,
  output logic [2*W-1:0]   o_max_ed,
  output logic [4*W-1:0]   o_sum_ed
);

  localparam int PW = cdm_pw(W);
  localparam int CW = cdm_cw(W);
  localparam int SW = cdm_sw(W);

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_max;
  logic [SW-1:0] r_sum;
  logic          w_clear;
  logic          w_load;
  logic          w_last;
  logic [PW-1:0] w_ed;
  logic          w_err;
  logic          w_valid;

  assign w_last = (&r_a) & (&r_b);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort has priority over start in IDLE and over progress in RUN/DRAIN.
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_next  = RUN;
          w_clear = 1'b1;
        end
      end
      RUN: begin
        if (i_abort) begin
          w_next = IDLE;
        end else begin
          w_load = 1'b1;
          if (w_last) begin
            w_next = DRAIN;
          end
        end
      end
      DRAIN:   w_next = i_abort ? IDLE : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // B is the inner index; the final pair is held so the multiplier output stays put.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_clear) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_load && !w_last) begin
      r_b <= r_b + 1'b1;
      if (&r_b) begin
        r_a <= r_a + 1'b1;
      end
    end
  end

  cdm_ed_stage #(.W(W)) u_ed_stage (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_a     (r_a),
    .i_b     (r_b),
    .i_r     (i_mult_r),
    .o_ed    (w_ed),
    .o_err   (w_err),
    .o_valid (w_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_max <= '0;
      r_sum <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
      r_max <= '0;
      r_sum <= '0;
    end else if (w_valid) begin
      r_cnt <= r_cnt + CW'(w_err);
      r_sum <= r_sum + SW'(w_ed);
      if (w_ed > r_max) begin
        r_max <= w_ed;
      end
    end
  end

  assign o_mult_a    = r_a;
  assign o_mult_b    = r_b;
  assign o_busy      = (r_state == RUN) || (r_state == DRAIN);
  assign o_done      = (r_state == DONE);
  assign o_err_count = r_cnt;
  assign o_max_ed    = r_max;
  assign o_sum_ed    = r_sum;

endmodule

// File: tb/tb_cdm_err_sweep_ctrl.sv
// Bench for the error-sweep controller: a W=2 instance driven by stub multipliers
// and a W=8 instance driven by an 8-bit carry-disregard multiplier.
module tb_cdm_err_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start2 = 1'b0, abort2 = 1'b0;
  logic [1:0]  a2, b2;
  logic [3:0]  r2;
  logic        busy2, done2;
  logic [4:0]  cnt2;
  logic [3:0]  max2;
  logic [7:0]  sum2;

  logic        start8 = 1'b0, abort8 = 1'b0;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        busy8, done8;
  logic [16:0] cnt8;
  logic [15:0] max8;
  logic [31:0] sum8;

  int          stubMode = 0;
  logic [63:0] lutBits = '0;
  int          nChecks = 0;
  int          nFails = 0;
  int          lastCnt = 0, lastMax = 0;
  longint      lastSum = 0;

  cdm_err_sweep_ctrl #(.W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_abort(abort2),
    .o_mult_a(a2), .o_mult_b(b2), .i_mult_r(r2), .o_busy(busy2), .o_done(done2),
    .o_err_count(cnt2), .o_max_ed(max2), .o_sum_ed(sum2)
  );

  cdm_err_sweep_ctrl #(.W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_abort(abort8),
    .o_mult_a(a8), .o_mult_b(b8), .i_mult_r(r8), .o_busy(busy8), .o_done(done8),
    .o_err_count(cnt8), .o_max_ed(max8), .o_sum_ed(sum8)
  );

  // Stub multipliers for W=2: exact, exact with LSB cleared, zero, random lookup.
  function automatic logic [3:0] stub2(input int mode, input logic [1:0] a, input logic [1:0] b,
                                       input logic [63:0] tab);
    logic [3:0] p;
    int idx;
    p = {2'b00, a} * {2'b00, b};
    idx = int'(a) * 4 + int'(b);
    case (mode)
      0:       return p;
      1:       return p & 4'b1110;
      2:       return 4'd0;
      default: return tab[idx*4 +: 4];
    endcase
  endfunction

  // 8-bit carry-disregard multiplier: low columns are XOR-reduced, high columns summed.
  function automatic logic [15:0] cdm8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] hi;
    logic [7:0]  lo;
    hi = '0;
    lo = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (a[i] && b[j]) begin
          if (i + j >= 8) hi = hi + (16'd1 << (i + j));
          else            lo[i+j] = ~lo[i+j];
        end
      end
    end
    return hi | {8'h00, lo};
  endfunction

  always_comb r2 = stub2(stubMode, a2, b2, lutBits);
  always_comb r8 = cdm8(a8, b8);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Metrics over the first n pairs of the W=2 sweep in A-outer, B-inner order.
  task automatic model2(input int mode, input logic [63:0] tab, input int n,
                        output int eCnt, output int eMax, output longint eSum);
    eCnt = 0; eMax = 0; eSum = 0;
    for (int k = 0; k < n; k++) begin
      int ex, ap, d;
      ex = (k / 4) * (k % 4);
      ap = int'(stub2(mode, 2'(k / 4), 2'(k % 4), tab));
      d  = (ex > ap) ? ex - ap : ap - ex;
      if (d != 0) eCnt++;
      eSum += d;
      if (d > eMax) eMax = d;
    end
  endtask

  // Runs one W=2 sweep, tallying busy and operand-order deviations and the done cycle.
  task automatic run_sweep2(input int extraStartAt, output int doneCyc,
                            output int busyErrs, output int orderErrs);
    doneCyc = -1; busyErrs = 0; orderErrs = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int cyc = 1; cyc <= 25 && doneCyc < 0; cyc++) begin
      int ea, eb;
      ea = (cyc <= 16) ? (cyc - 1) / 4 : 3;
      eb = (cyc <= 16) ? (cyc - 1) % 4 : 3;
      if (busy2 !== (cyc <= 17)) busyErrs++;
      if (cyc <= 17 && (a2 !== 2'(ea) || b2 !== 2'(eb))) orderErrs++;
      if (done2 === 1'b1) doneCyc = cyc;
      if (cyc == extraStartAt) start2 = 1'b1;
      tick();
      start2 = 1'b0;
    end
  endtask

  task automatic check_sweep2(input string tag, input int mode, input int doneCyc,
                              input int busyErrs, input int orderErrs);
    int eCnt, eMax;
    longint eSum;
    model2(mode, lutBits, 16, eCnt, eMax, eSum);
    nChecks++;
    if (doneCyc != 18) begin
      nFails++;
      $display("[TB] FAIL %s done_cycle: got %0d expected 18", tag, doneCyc);
    end
    nChecks++;
    if (busyErrs != 0) begin
      nFails++;
      $display("[TB] FAIL %s busy_window: got %0d bad cycles expected 0", tag, busyErrs);
    end
    nChecks++;
    if (orderErrs != 0) begin
      nFails++;
      $display("[TB] FAIL %s operand_order: got %0d bad cycles expected 0", tag, orderErrs);
    end
    nChecks++;
    if ({cnt2, max2, sum2} !== {5'(eCnt), 4'(eMax), 8'(eSum)}) begin
      nFails++;
      $display("[TB] FAIL %s totals: got cnt=%0d max=%0d sum=%0d expected cnt=%0d max=%0d sum=%0d",
               tag, cnt2, max2, sum2, eCnt, eMax, eSum);
    end
    lastCnt = eCnt; lastMax = eMax; lastSum = eSum;
  endtask

  task automatic test_reset();
    #1;
    nChecks++;
    if ({a2, b2, busy2, done2, cnt2, max2, sum2} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_w2: got %h expected 0", {a2, b2, busy2, done2, cnt2, max2, sum2});
    end
    nChecks++;
    if ({a8, b8, busy8, done8, cnt8, max8, sum8} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_w8: got %h expected 0", {a8, b8, busy8, done8, cnt8, max8, sum8});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stub_sweeps();
    int dc, be, oe;
    for (int mode = 0; mode < 4; mode++) begin
      stubMode = mode;
      lutBits = {$urandom, $urandom};
      run_sweep2(0, dc, be, oe);
      check_sweep2($sformatf("stub_mode%0d", mode), mode, dc, be, oe);
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_start_abort_idle();
    int doneSeen = 0, busySeen = 0;
    start2 = 1'b1; abort2 = 1'b1;
    tick();
    start2 = 1'b0; abort2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (busy2 !== 1'b0) busySeen++;
      if (done2 !== 1'b0) doneSeen++;
      tick();
    end
    nChecks++;
    if (busySeen + doneSeen != 0) begin
      nFails++;
      $display("[TB] FAIL start_abort_idle: got busy=%0d done=%0d cycles expected 0", busySeen, doneSeen);
    end
    nChecks++;
    if ({cnt2, max2, sum2} !== {5'(lastCnt), 4'(lastMax), 8'(lastSum)}) begin
      nFails++;
      $display("[TB] FAIL start_abort_hold: got cnt=%0d max=%0d sum=%0d expected cnt=%0d max=%0d sum=%0d",
               cnt2, max2, sum2, lastCnt, lastMax, lastSum);
    end
  endtask

  // Abort sampled k edges after the start edge leaves k-1 pairs accumulated.
  task automatic test_abort();
    int dc, be, oe, eCnt, eMax, doneSeen;
    longint eSum;
    for (int rep = 0; rep < 3; rep++) begin
      int k;
      k = (rep == 0) ? 5 : $urandom_range(1, 17);
      stubMode = 3;
      lutBits = {$urandom, $urandom};
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      repeat (k - 1) tick();
      abort2 = 1'b1;
      tick();
      abort2 = 1'b0;
      nChecks++;
      if (busy2 !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL abort_busy k=%0d: got %b expected 0", k, busy2);
      end
      doneSeen = 0;
      for (int i = 0; i < 20; i++) begin
        if (done2 !== 1'b0) doneSeen++;
        tick();
      end
      nChecks++;
      if (doneSeen != 0) begin
        nFails++;
        $display("[TB] FAIL abort_no_done k=%0d: got %0d done cycles expected 0", k, doneSeen);
      end
      model2(3, lutBits, k - 1, eCnt, eMax, eSum);
      nChecks++;
      if ({cnt2, max2, sum2} !== {5'(eCnt), 4'(eMax), 8'(eSum)}) begin
        nFails++;
        $display("[TB] FAIL abort_partial k=%0d: got cnt=%0d max=%0d sum=%0d expected cnt=%0d max=%0d sum=%0d",
                 k, cnt2, max2, sum2, eCnt, eMax, eSum);
      end
      run_sweep2(0, dc, be, oe);
      check_sweep2($sformatf("after_abort k=%0d", k), 3, dc, be, oe);
    end
  endtask

  task automatic test_start_while_busy();
    int dc, be, oe;
    stubMode = 2;
    run_sweep2($urandom_range(2, 16), dc, be, oe);
    check_sweep2("start_while_busy", 2, dc, be, oe);
    tick();
    nChecks++;
    if (busy2 !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL no_restart: got busy=%b expected 0", busy2);
    end
  endtask

  task automatic test_reset_mid_run();
    stubMode = 3;
    lutBits = {$urandom, $urandom};
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat ($urandom_range(4, 12)) tick();
    #2;
    rst = 1'b1;
    #1;
    nChecks++;
    if ({a2, b2, busy2, done2, cnt2, max2, sum2} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_run: got %h expected 0", {a2, b2, busy2, done2, cnt2, max2, sum2});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      tick();
      nChecks++;
      if (busy2 !== 1'b0 || done2 !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL after_reset_idle: got busy=%b done=%b expected 0 0", busy2, done2);
      end
    end
  endtask

  task automatic test_w8_sweep();
    int eCnt = 0, eMax = 0, doneCyc = -1, busyErrs = 0;
    longint eSum = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        int ex, ap, d;
        ex = a * b;
        ap = int'(cdm8(8'(a), 8'(b)));
        d  = (ex > ap) ? ex - ap : ap - ex;
        if (d != 0) eCnt++;
        eSum += d;
        if (d > eMax) eMax = d;
      end
    end
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int cyc = 1; cyc <= 70000; cyc++) begin
      if (busy8 !== (cyc <= 65537)) busyErrs++;
      if (done8 === 1'b1) begin
        doneCyc = cyc;
        break;
      end
      tick();
    end
    nChecks++;
    if (doneCyc != 65538) begin
      nFails++;
      $display("[TB] FAIL w8_done_cycle: got %0d expected 65538", doneCyc);
    end
    nChecks++;
    if (busyErrs != 0) begin
      nFails++;
      $display("[TB] FAIL w8_busy_window: got %0d bad cycles expected 0", busyErrs);
    end
    nChecks++;
    if ({cnt8, max8, sum8} !== {17'(eCnt), 16'(eMax), 32'(eSum)}) begin
      nFails++;
      $display("[TB] FAIL w8_totals: got cnt=%0d max=%0d sum=%0d expected cnt=%0d max=%0d sum=%0d",
               cnt8, max8, sum8, eCnt, eMax, eSum);
    end
  endtask

  initial begin
    test_reset();
    test_stub_sweeps();
    test_start_abort_idle();
    test_abort();
    test_start_while_busy();
    test_reset_mid_run();
    test_w8_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
